// File: rtl/muldiv_unit.sv
// Iterative 32-bit unsigned multiply/divide unit for the EX stage.
// One shift-add or restoring-divide step per cycle, 32 steps per operation.
module muldiv_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] data0_i,
  input  logic [31:0] data1_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic        valid_o,
  output logic [31:0] result_o
);

  localparam int DATA_W = 32;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic                accept;
  logic                finish;

  logic [1:0]          op_q;
  logic [4:0]          cnt_q;
  logic [2*DATA_W-1:0] opa_q;    // multiplicand (shifts left) or quotient in the low half
  logic [DATA_W-1:0]   opb_q;    // multiplier (shifts right) or divisor
  logic [2*DATA_W-1:0] acc_q;    // product accumulator or partial remainder in the low half
  logic [DATA_W-1:0]   result_q;

  logic [2*DATA_W-1:0] mul_acc_nxt;
  logic [2*DATA_W-1:0] div_nxt;
  logic [DATA_W-1:0]   rem_nxt;
  logic [DATA_W-1:0]   quot_nxt;
  logic [DATA_W-1:0]   result_sel;

  // One shift-add step: add the aligned multiplicand when the current multiplier bit is set.
  function automatic logic [2*DATA_W-1:0] mul_step(
    input logic [2*DATA_W-1:0] acc,
    input logic [2*DATA_W-1:0] mcand,
    input logic                mbit
  );
    return mbit ? (acc + mcand) : acc;
  endfunction

  // One restoring step on {rem, quot}; returns {rem, quot}.
  // A zero divisor always "succeeds", which yields all-ones quotient and rem == dividend.
  function automatic logic [2*DATA_W-1:0] div_step(
    input logic [DATA_W-1:0] rem,
    input logic [DATA_W-1:0] quot,
    input logic [DATA_W-1:0] dvsr
  );
    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;
    shifted = {rem, quot[DATA_W-1]};
    diff    = shifted - {1'b0, dvsr};
    if (!diff[DATA_W])
      return {diff[DATA_W-1:0], quot[DATA_W-2:0], 1'b1};
    else
      return {shifted[DATA_W-1:0], quot[DATA_W-2:0], 1'b0};
  endfunction

  always_comb begin
    mul_acc_nxt = mul_step(acc_q, opa_q, opb_q[0]);
    div_nxt     = div_step(acc_q[DATA_W-1:0], opa_q[DATA_W-1:0], opb_q);
    rem_nxt     = div_nxt[2*DATA_W-1:DATA_W];
    quot_nxt    = div_nxt[DATA_W-1:0];
    case (op_q)
      OP_MUL:   result_sel = mul_acc_nxt[DATA_W-1:0];
      OP_MULHU: result_sel = mul_acc_nxt[2*DATA_W-1:DATA_W];
      OP_DIVU:  result_sel = quot_nxt;
      OP_REMU:  result_sel = rem_nxt;
      default:  result_sel = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Flush overrides everything; reset is folded in so a start during reset is never accepted.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 5'd0) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (start_i) begin
          accept  = 1'b1;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_i || rst_i) begin
      accept  = 1'b0;
      finish  = 1'b0;
      state_d = IDLE;
    end
  end

  // Iteration datapath
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q  <= op_i;
      cnt_q <= 5'd31;
      opa_q <= {{DATA_W{1'b0}}, data0_i};
      opb_q <= data1_i;
      acc_q <= '0;
    end else if (state_q == BUSY && !flush_i) begin
      cnt_q <= cnt_q - 5'd1;
      if (op_q[1]) begin
        acc_q <= {{DATA_W{1'b0}}, rem_nxt};
        opa_q <= {{DATA_W{1'b0}}, quot_nxt};
      end else begin
        acc_q <= mul_acc_nxt;
        opa_q <= opa_q << 1;
        opb_q <= opb_q >> 1;
      end
      if (finish) result_q <= result_sel;
    end
  end

  assign busy_o   = (state_q == BUSY);
  assign valid_o  = (state_q == DONE);
  assign stall_o  = accept | busy_o;
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table of single ops plus flush, overlap,
// back-to-back and mid-operation reset sequences.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] data0_i = '0;
  logic [31:0] data1_i = '0;
  logic        flush_i = 1'b0;
  logic        busy_o, stall_o, valid_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[14];

  muldiv_unit dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .op_i     (op_i),
    .data0_i  (data0_i),
    .data1_i  (data1_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .stall_o  (stall_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one operation in the current cycle C and checks it through C+34.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name);
    int bad;
    start_i = 1'b1; op_i = op; data0_i = a; data1_i = b;
    #1;
    check({name, "_stall_C"}, {31'b0, stall_o}, 32'd1);
    tick();
    start_i = 1'b0;
    bad = 0;
    for (int i = 1; i <= 32; i++) begin
      if (busy_o !== 1'b1 || stall_o !== 1'b1 || valid_o !== 1'b0) bad++;
      tick();
    end
    check({name, "_busy_window"}, bad, 32'd0);
    check({name, "_valid_C33"}, {29'b0, valid_o, busy_o, stall_o}, 32'b100);
    check({name, "_result"}, result_o, exp);
    tick();
    check({name, "_valid_C34"}, {31'b0, valid_o}, 32'd0);
    check({name, "_hold_C34"}, result_o, exp);
  endtask

  initial begin
    int bad;
    logic [31:0] prev;

    vecs[0]  = '{2'b00, 32'd7,          32'd6,          32'd42,         "mul_7x6"};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   "mulhu_max"};
    vecs[2]  = '{2'b00, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001,   "mul_max"};
    vecs[3]  = '{2'b10, 32'd100,        32'd7,          32'd14,         "divu_100_7"};
    vecs[4]  = '{2'b11, 32'd100,        32'd7,          32'd2,          "remu_100_7"};
    vecs[5]  = '{2'b10, 32'd5,          32'd0,          32'hFFFFFFFF,   "divu_by0"};
    vecs[6]  = '{2'b11, 32'd5,          32'd0,          32'd5,          "remu_by0"};
    vecs[7]  = '{2'b01, 32'h80000000,   32'd4,          32'd2,          "mulhu_msb"};
    vecs[8]  = '{2'b00, 32'h80000000,   32'd4,          32'd0,          "mul_msb"};
    vecs[9]  = '{2'b01, 32'h00010000,   32'h00010000,   32'd1,          "mulhu_2p32"};
    vecs[10] = '{2'b10, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   "divu_max_1"};
    vecs[11] = '{2'b11, 32'hFFFFFFFF,   32'h10,         32'h0000000F,   "remu_max_16"};
    vecs[12] = '{2'b10, 32'd3,          32'd5,          32'd0,          "divu_small"};
    vecs[13] = '{2'b11, 32'd3,          32'd5,          32'd3,          "remu_small"};

    // Reset state
    tick(); tick();
    check("reset_outputs", {28'b0, busy_o, valid_o, stall_o, 1'b0}, 32'd0);
    check("reset_result", result_o, 32'd0);
    rst_i = 1'b0;
    tick();

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
    prev = vecs[13].exp;

    // Flush at C+10
    start_i = 1'b1; op_i = 2'b00; data0_i = 32'd9; data1_i = 32'd9;
    tick();
    start_i = 1'b0;
    repeat (9) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_busy_C11", {31'b0, busy_o}, 32'd0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_o !== 1'b0) bad++;
      tick();
    end
    check("flush_no_valid", bad, 32'd0);
    check("flush_result_kept", result_o, prev);

    // Start held during BUSY with different operands is ignored
    start_i = 1'b1; op_i = 2'b10; data0_i = 32'd100; data1_i = 32'd7;
    tick();
    op_i = 2'b00; data0_i = 32'd2; data1_i = 32'd2;
    repeat (32) tick();
    start_i = 1'b0;
    #1;
    check("overlap_valid", {31'b0, valid_o}, 32'd1);
    check("overlap_result", result_o, 32'd14);
    tick();

    // Back-to-back: second start in the DONE cycle
    start_i = 1'b1; op_i = 2'b00; data0_i = 32'd7; data1_i = 32'd6;
    tick();
    start_i = 1'b0;
    repeat (32) tick();
    check("b2b_first_result", result_o, 32'd42);
    check("b2b_first_valid", {31'b0, valid_o}, 32'd1);
    start_i = 1'b1; op_i = 2'b11; data0_i = 32'd100; data1_i = 32'd7;
    #1;
    check("b2b_stall_accept", {31'b0, stall_o}, 32'd1);
    tick();
    start_i = 1'b0;
    check("b2b_busy_C34", {30'b0, busy_o, valid_o}, 32'b10);
    repeat (31) tick();
    check("b2b_not_early", {31'b0, valid_o}, 32'd0);
    tick();
    check("b2b_second_valid_C66", {31'b0, valid_o}, 32'd1);
    check("b2b_second_result", result_o, 32'd2);
    tick();

    // Reset mid-BUSY at C+20
    start_i = 1'b1; op_i = 2'b00; data0_i = 32'd3; data1_i = 32'd5;
    tick();
    start_i = 1'b0;
    repeat (19) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rst_mid_flags", {30'b0, busy_o, valid_o}, 32'd0);
    check("rst_mid_result", result_o, 32'd0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_o !== 1'b0 || busy_o !== 1'b0) bad++;
      tick();
    end
    check("rst_no_valid_after", bad, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit unsigned multiply/divide unit for the RV32 pipeline's EX stage. It sits directly downstream of the EX-stage forwarding operand multiplexers and takes their forwarded rs1/rs2 values as operands. It computes MUL, MULHU, DIVU or REMU over a fixed 32-iteration sequence. While it works, it raises a stall to the hazard logic, then presents a one-cycle-valid result to the EX/MEM write-back path.

## Interface
Parameters:
- none (operand width fixed at 32, iteration count fixed at 32)

Ports:
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  synchronous reset, active-high
- start_i  input  1  request a new operation; sampled only when the unit is IDLE or DONE
- op_i  input  2  operation: 00 MUL (low 32 of product), 01 MULHU (high 32 of unsigned product), 10 DIVU (unsigned quotient), 11 REMU (unsigned remainder)
- data0_i  input  32  operand A (rs1 after forwarding): multiplicand or dividend
- data1_i  input  32  operand B (rs2 after forwarding): multiplier or divisor
- flush_i  input  1  abort any in-flight operation; result is discarded
- busy_o  output  1  high while the unit is iterating
- stall_o  output  1  pipeline stall request: combinational (start_i accepted) OR busy_o
- valid_o  output  1  single-cycle pulse: result_o is newly valid
- result_o  output  32  result; holds its last value until the next operation completes

## Operation
- States: IDLE, BUSY, DONE. Reset sets the state to IDLE.
- Reset values: busy_o=0, valid_o=0, result_o=0. The iteration counter, operand registers and accumulator are also cleared. stall_o follows its combinational definition.
- IDLE: on start_i=1 (and flush_i=0), do the following, then go to BUSY with counter=31:
  - latch op_i, data0_i and data1_i;
  - for multiply, clear the 64-bit accumulator;
  - for divide, clear the 33-bit partial remainder and load the quotient register with data0_i.
- BUSY, multiply: shift-add one multiplier bit per cycle, LSB first. After 32 iterations the accumulator holds the full 64-bit unsigned product.
- BUSY, divide: one restoring step per cycle, as follows:
  - shift {rem, quot} left by 1;
  - trial-subtract the divisor from rem;
  - if the difference is non-negative, keep it and set quot[0]=1; otherwise restore rem and set quot[0]=0.
- BUSY exit: when counter==0 the iteration completes, the state goes to DONE and result_o is loaded by op:
  - MUL: product[31:0];
  - MULHU: product[63:32];
  - DIVU: the quotient;
  - REMU: the remainder.
- Divide by zero needs no special path; the restoring algorithm produces the RISC-V-mandated values naturally:
  - DIVU by 0 gives 0xFFFFFFFF;
  - REMU by 0 gives the dividend.
- DONE: valid_o=1 for exactly this cycle.
  - With start_i=1: accept the new operation as in IDLE and go to BUSY.
  - Otherwise: go to IDLE.
- start_i during BUSY is ignored, and the operands are not re-latched.
- flush_i=1 in any state sends the next state to IDLE. It drops busy_o and suppresses valid_o for the aborted operation, and it leaves result_o unchanged. When flush_i and start_i are both high, flush wins and nothing is accepted.
- rst_i has priority over flush_i and start_i.
- Arithmetic is unsigned only. There is no signed handling and no overflow flag.

## Timing
- Let C be the cycle in which start_i=1 is sampled while the state is IDLE or DONE.
- stall_o=1 in cycle C (combinational).
- busy_o=1 and stall_o=1 in cycles C+1 through C+32 (32 cycles).
- In cycle C+33: valid_o=1, busy_o=0, stall_o=0, and result_o is final. Latency from start to valid is 33 cycles.
- In cycle C+34: valid_o=0 and result_o holds, unless a back-to-back start was accepted in C+33, in which case busy_o=1.
- Back-to-back throughput is one operation per 33 cycles.
- Flush asserted in cycle F during BUSY: busy_o=0 in cycle F+1, and valid_o never pulses for that operation.
- Reset asserted in cycle R: all outputs are at their reset values in cycle R+1, whatever the previous state.

## Test plan
- MUL with data0_i=7, data1_i=6, start at C: busy_o is high C+1..C+32; valid_o=1 at C+33 with result_o=42; valid_o=0 at C+34 with result_o still 42.
- MULHU with 0xFFFFFFFF × 0xFFFFFFFF: result_o=0xFFFFFFFE at C+33. MUL on the same operands gives 0x00000001.
- DIVU 100/7 gives result_o=14; REMU 100/7 gives 2. DIVU 5/0 gives 0xFFFFFFFF; REMU 5/0 gives 5. Every case completes at C+33.
- Abort and overlap:
  - flush_i pulsed at C+10: busy_o=0 at C+11, no valid_o pulse, result_o keeps its previous value.
  - start_i held high with new operands during C+1..C+32: ignored, and the original result is still returned at C+33.
- Back-to-back: second start_i asserted in the DONE cycle C+33. busy_o=1 at C+34, and the second valid_o arrives at C+66 with the second op's result.
- rst_i asserted mid-BUSY at C+20: busy_o, valid_o and result_o are 0 at C+21. With no new start, no valid_o pulse follows.
